// File: rtl/clock_strobe_gen_pkg.sv
// clock_strobe_pkg: default geometry for clock_strobe_gen and the divisor
// constants used by the clock application (12.5 kHz clk, 125-cycle base tick,
// i.e. a 100 Hz base rate).
package clock_strobe_pkg;
  localparam int BASE_DIV_DEF = 125;
  localparam int NUM_CH_DEF   = 3;
  localparam int DIV_W_DEF    = 8;

  // Channel divisors in base ticks at BASE_DIV_DEF.
  localparam logic [DIV_W_DEF-1:0] DIV_REFRESH = 8'd1;    // 100 Hz display refresh
  localparam logic [DIV_W_DEF-1:0] DIV_SET     = 8'd25;   // 4 Hz set-button repeat
  localparam logic [DIV_W_DEF-1:0] DIV_1HZ     = 8'd100;  // 1 Hz timekeeping
endpackage

// File: rtl/clock_strobe_gen_channel.sv
// strobe_channel: divides the shared base tick by a runtime divisor.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   clr            synchronous phase clear (same effect as reset)
//   base_tick      1-cycle pulse from the shared prescaler
//   div            divisor in base ticks; 0 disables the channel
//   strobe         1-cycle pulse on each wrap
//   level          toggles on each wrap (50% duty square wave)
module strobe_channel #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             base_tick,
  input  logic [DIV_W-1:0] div,
  output logic             strobe,
  output logic             level
);
  logic [DIV_W-1:0] ch_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      ch_cnt <= '0;
      strobe <= 1'b0;
      level  <= 1'b0;
    end else if (div == '0) begin
      ch_cnt <= '0;
      strobe <= 1'b0;
      level  <= 1'b0;
    end else if (base_tick) begin
      // >= rather than == so a divisor shrunk below the running count
      // wraps on the next tick instead of running out to 2^DIV_W.
      if (ch_cnt >= div - DIV_W'(1)) begin
        ch_cnt <= '0;
        strobe <= 1'b1;
        level  <= ~level;
      end else begin
        ch_cnt <= ch_cnt + DIV_W'(1);
        strobe <= 1'b0;
      end
    end else begin
      strobe <= 1'b0;
    end
  end
endmodule

// File: rtl/clock_strobe_gen.sv
// clock_strobe_gen: shared prescaler plus NUM_CH programmable tick channels.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   ena            prescaler run enable
//   sync_clr       synchronous phase clear, priority over ena
//   div_i          packed channel divisors, ch i = div_i[i*DIV_W +: DIV_W]
//   base_tick_o    1-cycle pulse per prescaler wrap
//   strobe_o       1-cycle pulse per channel wrap
//   level_o        per-channel square wave, toggles on each wrap
module clock_strobe_gen
  import clock_strobe_pkg::*;
#(
  parameter int BASE_DIV = BASE_DIV_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ena,
  input  logic                    sync_clr,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic                    base_tick_o,
  output logic [NUM_CH-1:0]       strobe_o,
  output logic [NUM_CH-1:0]       level_o
);
  localparam int PRE_W = (BASE_DIV <= 2) ? 1 : $clog2(BASE_DIV);

  logic [PRE_W-1:0] pre_cnt;

  // Prescaler; the tick is registered so it lands the cycle after the wrap.
  always_ff @(posedge clk) begin
    if (!reset_n || sync_clr) begin
      pre_cnt     <= '0;
      base_tick_o <= 1'b0;
    end else if (ena) begin
      if (pre_cnt == PRE_W'(BASE_DIV - 1)) begin
        pre_cnt     <= '0;
        base_tick_o <= 1'b1;
      end else begin
        pre_cnt     <= pre_cnt + PRE_W'(1);
        base_tick_o <= 1'b0;
      end
    end else begin
      base_tick_o <= 1'b0;
    end
  end

  // Channels consume base_tick_o regardless of ena, so a tick already
  // issued when ena drops is still counted.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    strobe_channel #(.DIV_W(DIV_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (sync_clr),
      .base_tick(base_tick_o),
      .div      (div_i[i*DIV_W +: DIV_W]),
      .strobe   (strobe_o[i]),
      .level    (level_o[i])
    );
  end
endmodule

// File: tb/tb_clock_strobe_gen.sv
module tb_clock_strobe_gen;
  import clock_strobe_pkg::*;

  localparam int BD = 4;
  localparam int NC = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small-geometry DUT, checked against the model every cycle
  logic             reset_n, ena, sync_clr;
  logic [NC*DW-1:0] div;
  logic             base_tick;
  logic [NC-1:0]    strobe, level;

  clock_strobe_gen #(.BASE_DIV(BD), .NUM_CH(NC), .DIV_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .sync_clr(sync_clr), .div_i(div),
    .base_tick_o(base_tick), .strobe_o(strobe), .level_o(level)
  );

  // default-geometry DUT for the long-run count test
  logic                  reset2_n, ena2, clr2;
  logic [3*DIV_W_DEF-1:0] div2;
  logic                  tick2;
  logic [2:0]            strobe2, level2;

  clock_strobe_gen dut2 (
    .clk(clk), .reset_n(reset2_n), .ena(ena2), .sync_clr(clr2), .div_i(div2),
    .base_tick_o(tick2), .strobe_o(strobe2), .level_o(level2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: k = enabled edges since reset/clear; a base tick follows
  // every edge where k is a multiple of BD. Each channel tracks how many base
  // ticks it has seen since its last wrap.
  int k;
  bit m_tick;
  int m_seen [NC];
  bit m_str  [NC];
  bit m_lvl  [NC];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic step();
    bit prev_tick;
    int d;
    @(posedge clk);
    prev_tick = m_tick;
    if (!reset_n || sync_clr) begin
      k = 0;
      m_tick = 0;
      for (int i = 0; i < NC; i++) begin
        m_seen[i] = 0; m_str[i] = 0; m_lvl[i] = 0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        d = int'(div[i*DW +: DW]);
        if (d == 0) begin
          m_seen[i] = 0; m_str[i] = 0; m_lvl[i] = 0;
        end else if (prev_tick) begin
          if (m_seen[i] + 1 >= d) begin
            m_seen[i] = 0; m_str[i] = 1; m_lvl[i] = !m_lvl[i];
          end else begin
            m_seen[i] = m_seen[i] + 1; m_str[i] = 0;
          end
        end else begin
          m_str[i] = 0;
        end
      end
      if (ena) begin
        k++;
        m_tick = (k % BD == 0);
      end else begin
        m_tick = 0;
      end
    end
    #1;
    check("base_tick", int'(base_tick), int'(m_tick));
    for (int i = 0; i < NC; i++) begin
      check($sformatf("strobe[%0d]", i), int'(strobe[i]), int'(m_str[i]));
      check($sformatf("level[%0d]", i), int'(level[i]), int'(m_lvl[i]));
    end
  endtask

  initial begin
    int tk_q[$], s0_q[$], s1_q[$], l1_q[$];
    int s2_hits, n, ticks_p, str_p;
    int c0, c1, c2, f0, f2;
    logic l1_prev;

    reset2_n = 1'b0; ena2 = 1'b1; clr2 = 1'b0;
    div2 = {DIV_1HZ, DIV_SET, DIV_REFRESH};

    // 1. reset with random inputs
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ena = 1'($urandom); sync_clr = 1'($urandom); div = NC*DW'($urandom);
      step();
      check("rst_outs", int'({base_tick, strobe, level}), 0);
    end
    check("rst_dut2", int'({tick2, strobe2, level2}), 0);

    // 2. ena=1, div={0,5,1}
    reset_n = 1'b1; ena = 1'b1; sync_clr = 1'b0;
    div = {8'd0, 8'd5, 8'd1};
    s2_hits = 0; l1_prev = 1'b0;
    for (int c = 0; c < 66; c++) begin
      step();
      if (base_tick) tk_q.push_back(k);
      if (strobe[0]) s0_q.push_back(k);
      if (strobe[1]) s1_q.push_back(k);
      if (level[1] != l1_prev) l1_q.push_back(k);
      l1_prev = level[1];
      if (strobe[2] || level[2]) s2_hits++;
    end
    check("tick_1st", qget(tk_q, 0), 4);
    check("tick_2nd", qget(tk_q, 1), 8);
    check("tick_3rd", qget(tk_q, 2), 12);
    check("s0_1st", qget(s0_q, 0), 5);
    check("s0_2nd", qget(s0_q, 1), 9);
    check("s1_1st", qget(s1_q, 0), 21);
    check("s1_2nd", qget(s1_q, 1), 41);
    check("l1_period", qget(l1_q, 2) - qget(l1_q, 0), 40);
    check("ch2_silent", s2_hits, 0);

    // 3. pause at pre_cnt=2 (k=66)
    ena = 1'b0; ticks_p = 0; str_p = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (base_tick) ticks_p++;
      if (strobe != '0) str_p++;
    end
    check("pause_ticks", ticks_p, 0);
    check("pause_strobes", str_p, 0);
    ena = 1'b1; n = 0;
    do begin step(); n++; end while (!base_tick && n < 10);
    check("resume_edges", n, 2);

    // 4. sync_clr mid-count
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    check("clr_outs", int'({base_tick, strobe, level}), 0);
    for (int c = 0; c < 100 && m_seen[1] != 3; c++) step();
    check("reach_cnt3", m_seen[1], 3);
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    check("clr2_outs", int'({base_tick, strobe, level}), 0);
    n = 0;
    do begin step(); n++; end while (!strobe[1] && n < 50);
    check("clr_s1_edge", n, 21);

    // 5. divisor change 5 -> 2 at count 3, then disable
    for (int c = 0; c < 100 && m_seen[1] != 3; c++) step();
    check("reach_cnt3b", m_seen[1], 3);
    div[1*DW +: DW] = 8'd2;
    n = 0;
    do begin step(); n++; end while (!strobe[1] && n < 8);
    check("shrink_wrap_edges", n, 4);
    check("shrink_level", int'(level[1]), 0);
    div[1*DW +: DW] = 8'd0;
    step();
    check("dis_level", int'(level[1]), 0);
    check("dis_strobe", int'(strobe[1]), 0);

    // random stress against the model
    for (int c = 0; c < 800; c++) begin
      reset_n  = ($urandom_range(99) != 0);
      sync_clr = ($urandom_range(49) == 0);
      ena      = ($urandom_range(9) < 8);
      if ($urandom_range(19) == 0)
        div[$urandom_range(NC-1)*DW +: DW] = 8'($urandom_range(6));
      step();
    end

    // 6. defaults: 12501 enabled edges at BASE_DIV=125, div={100,25,1}
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset2_n = 1'b1;
    c0 = 0; c1 = 0; c2 = 0; f0 = -1; f2 = -1;
    for (int e = 1; e <= 12501; e++) begin
      @(posedge clk); #1;
      if (strobe2[0]) begin c0++; if (f0 < 0) f0 = e; end
      if (strobe2[1]) c1++;
      if (strobe2[2]) begin c2++; if (f2 < 0) f2 = e; end
    end
    check("def_s0_count", c0, 100);
    check("def_s1_count", c1, 4);
    check("def_s2_count", c2, 1);
    check("def_s0_first", f0, 126);
    check("def_s2_first", f2, 12501);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
